// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I core front end.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// buffers the returned word toward decode and discards stale responses
// after a redirect.
module pc_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        pc_sel,
  output logic [31:0] pc_four,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam logic [31:0] ALIGN_MASK = ~32'd3;

  fetch_state_t state, state_n;
  logic [31:0]  pc_n;
  logic [31:0]  inst_n;
  logic [31:0]  inst_pc_n;
  logic         inst_valid_n;
  logic         handshake;
  logic         redirect;

  // Outputs derived only from registered state.
  assign pc_four        = pc + INST_BYTES;
  assign imem_req_valid = (state == REQ) && !inst_valid;
  assign imem_req_addr  = pc;

  assign handshake = imem_req_valid && imem_req_ready;
  assign redirect  = pc_sel && (state != IDLE);

  // Next-state, PC and output-buffer update; redirect outranks a response.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid && !inst_ready;

    if (redirect) begin
      pc_n         = pc_next & ALIGN_MASK;
      inst_valid_n = 1'b0;
    end

    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        // A redirect racing the handshake leaves an old-PC request in flight.
        if (handshake) state_n = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_n = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          inst_n       = imem_rsp_data;
          inst_pc_n    = pc;
          inst_valid_n = 1'b1;
          pc_n         = pc_next & ALIGN_MASK;
          state_n      = REQ;
        end
      end
      DROP: begin
        if (!redirect && imem_rsp_valid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC & ALIGN_MASK;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
    end
  end

endmodule
